nfs_open_remove_dispatcher: RTL

Call scheduler that sits in front of one `nfs_open_file_remove_open_find` kernel instance. It queues open-removal requests from the NFS4 request path and issues them to the kernel one call at a time over the kernel's start/busy/done/stall handshake. It assigns each call a per-tag result buffer in memory and returns a tagged completion. A watchdog recovers a hung kernel by pulsing the kernel's reset and reporting an error completion.

---
 rtl/nfs_open_pkg.sv | 27 ++
 rtl/nfs_req_fifo.sv | 47 ++++
 rtl/nfs_open_remove_dispatcher.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/nfs_open_pkg.sv
// Shared types and constants for the NFS open-removal call dispatcher.
package nfs_open_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RECOVER
  } disp_state_e;

  localparam int unsigned RESULT_STRIDE = 24;

  localparam logic [31:0] NFS_OPEN_SHARE_ACCESS_READ  = 32'd1;
  localparam logic [31:0] NFS_OPEN_SHARE_ACCESS_WRITE = 32'd2;
  localparam logic [31:0] NFS_OPEN_SHARE_ACCESS_BOTH  = 32'd3;
  localparam logic [31:0] NFS_OPEN_SHARE_DENY_NONE    = 32'd0;
  localparam logic [31:0] NFS_OPEN_SHARE_DENY_READ    = 32'd1;
  localparam logic [31:0] NFS_OPEN_SHARE_DENY_WRITE   = 32'd2;

  // Per-tag result slot address; 64-bit arithmetic wraps modulo 2^64.
  function automatic logic [63:0] result_addr(input logic [63:0] base,
                                              input logic [63:0] tag,
                                              input logic [63:0] offset);
    return base + tag * 64'(RESULT_STRIDE) + offset;
  endfunction

endpackage

// File: rtl/nfs_req_fifo.sv
// Synchronous request FIFO; full/empty derive from the registered count.
module nfs_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/nfs_open_remove_dispatcher.sv
// Queues open-removal requests and runs them one at a time on the kernel,
// with a watchdog that resets a hung kernel and reports an error completion.
module nfs_open_remove_dispatcher
  import nfs_open_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAG_W      = 8,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_nofp,
  input  logic [31:0]      req_access,
  input  logic [31:0]      req_deny,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  input  logic [63:0]      cfg_result_base,
  output logic             k_start,
  input  logic             k_busy,
  input  logic             k_done,
  output logic             k_stall,
  output logic             k_resetn,
  output logic [63:0]      k_nofp,
  output logic [31:0]      k_accessMode,
  output logic [31:0]      k_denyMode,
  output logic [63:0]      k_newAccessMode,
  output logic [63:0]      k_newDenyMode,
  output logic [63:0]      k_delegated,
  output logic [15:0]      err_count
);
  localparam int unsigned FW = 128 + TAG_W;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  disp_state_e      state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic             live_q;
  logic [63:0]      nofp_q, nofp_d, nam_q, nam_d, ndm_q, ndm_d, dlg_q, dlg_d;
  logic [31:0]      acc_q, acc_d, deny_q, deny_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d, rsp_tag_q, rsp_tag_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]    fifo_wdata, fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic             unused_count;
  logic [TAG_W-1:0] head_tag;

  assign fifo_wdata   = {req_nofp, req_access, req_deny, req_tag};
  assign head_tag     = fifo_rdata[TAG_W-1:0];
  assign unused_count = ^fifo_count;

  nfs_req_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk_i   (clock),
    .rst_ni  (resetn),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // live_q holds every output low during reset, including req_ready and k_resetn.
  assign req_ready       = live_q && !fifo_full;
  assign fifo_push       = req_valid && req_ready;
  assign k_start         = (state_q == ST_ISSUE);
  assign k_stall         = (state_q == ST_WAIT) && rsp_valid_q && !rsp_ready;
  assign k_resetn        = live_q && (state_q != ST_RECOVER);
  assign k_nofp          = nofp_q;
  assign k_accessMode    = acc_q;
  assign k_denyMode      = deny_q;
  assign k_newAccessMode = nam_q;
  assign k_newDenyMode   = ndm_q;
  assign k_delegated     = dlg_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_tag         = rsp_tag_q;
  assign rsp_err         = rsp_err_q;
  assign err_count       = err_cnt_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rcnt_d      = rcnt_q;
    nofp_d      = nofp_q;
    acc_d       = acc_q;
    deny_d      = deny_q;
    nam_d       = nam_q;
    ndm_d       = ndm_q;
    dlg_d       = dlg_q;
    cur_tag_d   = cur_tag_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          nofp_d    = fifo_rdata[FW-1 -: 64];
          acc_d     = fifo_rdata[TAG_W+63 -: 32];
          deny_d    = fifo_rdata[TAG_W+31 -: 32];
          nam_d     = result_addr(cfg_result_base, 64'(head_tag), 64'd0);
          ndm_d     = result_addr(cfg_result_base, 64'(head_tag), 64'd8);
          dlg_d     = result_addr(cfg_result_base, 64'(head_tag), 64'd16);
          cur_tag_d = head_tag;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!k_busy) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
      end
      ST_WAIT: begin
        // An accepted done takes priority over a timer expiring in the same cycle.
        if (k_done && !k_stall) begin
          rsp_valid_d = 1'b1;
          rsp_tag_d   = cur_tag_q;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end else if (!k_stall) begin
          if (timer_q == TW'(TIMEOUT - 1)) begin
            rsp_valid_d = 1'b1;
            rsp_tag_d   = cur_tag_q;
            rsp_err_d   = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            rcnt_d      = '0;
            state_d     = ST_RECOVER;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      ST_RECOVER: begin
        if (rcnt_q == RW'(RST_CYCLES - 1)) state_d = ST_IDLE;
        else                               rcnt_d  = rcnt_q + RW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      rcnt_q      <= '0;
      live_q      <= 1'b0;
      nofp_q      <= '0;
      acc_q       <= '0;
      deny_q      <= '0;
      nam_q       <= '0;
      ndm_q       <= '0;
      dlg_q       <= '0;
      cur_tag_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rcnt_q      <= rcnt_d;
      live_q      <= 1'b1;
      nofp_q      <= nofp_d;
      acc_q       <= acc_d;
      deny_q      <= deny_d;
      nam_q       <= nam_d;
      ndm_q       <= ndm_d;
      dlg_q       <= dlg_d;
      cur_tag_q   <= cur_tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule
